fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer_if.sv | 48 ++++
 rtl/fetch_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Bundle of the fetch sequencer's PC-register, instruction-
//                memory and decode-stage signals. The master modport is the
//                sequencer's view; the slave modport is the surrounding
//                PC register / memory / decode view.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_sequencer_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 32
);
   // PC register side
   logic               fetch_en;
   logic [ADDR_W-1:0]  pc_current_address;
   logic               load;
   logic [ADDR_W-1:0]  pc_target_addr;
   // Instruction memory side
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   // Decode side
   logic               inst_valid;
   logic               inst_ready;
   logic [INSTR_W-1:0] inst_data;
   logic [ADDR_W-1:0]  inst_pc;
   // Redirect / status
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_addr;
   logic               misalign_err;

   modport master (
      input  fetch_en, pc_current_address, imem_ack, imem_rdata,
             inst_ready, redirect_valid, redirect_addr,
      output load, pc_target_addr, imem_req, imem_addr,
             inst_valid, inst_data, inst_pc, misalign_err
   );

   modport slave (
      output fetch_en, pc_current_address, imem_ack, imem_rdata,
             inst_ready, redirect_valid, redirect_addr,
      input  load, pc_target_addr, imem_req, imem_addr,
             inst_valid, inst_data, inst_pc, misalign_err
   );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction-fetch sequencer. Reads the current PC, runs a
//                req/ack fetch to instruction memory, holds the word for
//                decode under valid/ready, then pulses load with the next
//                sequential or redirected PC.
//                Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned
//                redirect detection and target word-alignment).
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 32,
   parameter int PC_STEP = 4
) (
   input  wire                 clk,
   input  wire                 rst,     // asynchronous, active-low
   fetch_sequencer_if.master   bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_HOLD   = 3'd2,
      S_DRAIN  = 3'd3,
      S_UPDATE = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(PC_STEP);

   state_t             r_state;
   logic [ADDR_W-1:0]  r_addr;        // address of the fetch in flight / held
   logic               r_imem_req;
   logic [ADDR_W-1:0]  r_imem_addr;
   logic               r_inst_valid;
   logic [INSTR_W-1:0] r_inst_data;
   logic [ADDR_W-1:0]  r_inst_pc;

   logic               w_accept;
   logic               w_load;
   logic [ADDR_W-1:0]  w_target;
   logic [ADDR_W-1:0]  w_redir_addr;
   logic               w_misalign_err;

   // Decode takes the held word this cycle
   assign w_accept = (r_state == S_HOLD) && r_inst_valid && bus.inst_ready;

`ifdef FETCH_ALIGN_CHECK_EN
   logic r_misalign;

   // Redirect targets are forced onto a word boundary
   assign w_redir_addr = {bus.redirect_addr[ADDR_W-1:2], 2'b00};

   // Sticky flag: any redirect with low address bits set, cleared only by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_misalign <= 1'b0;
      end else if (bus.redirect_valid && (bus.redirect_addr[1:0] != 2'b00)) begin
         r_misalign <= 1'b1;
      end
   end

   assign w_misalign_err = r_misalign;
`else
   assign w_redir_addr   = bus.redirect_addr;
   assign w_misalign_err = 1'b0;
`endif

   // load/target are combinational so the PC register updates on the same
   // edge as the accept or redirect; redirect wins over a simultaneous accept
   always_comb begin
      w_load   = 1'b0;
      w_target = '0;
      if (bus.redirect_valid) begin
         w_load   = 1'b1;
         w_target = w_redir_addr;
      end else if (w_accept) begin
         w_load   = 1'b1;
         w_target = r_addr + C_PC_STEP;   // wraps modulo 2^ADDR_W
      end
   end

   // Fetch state machine with registered memory/decode outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_imem_req   <= 1'b0;
         r_imem_addr  <= '0;
         r_inst_valid <= 1'b0;
         r_inst_data  <= '0;
         r_inst_pc    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.redirect_valid) begin
                  r_state <= S_UPDATE;
               end else if (bus.fetch_en) begin
                  r_addr      <= bus.pc_current_address;
                  r_imem_req  <= 1'b1;
                  r_imem_addr <= bus.pc_current_address;
                  r_state     <= S_REQ;
               end
            end

            S_REQ: begin
               if (bus.redirect_valid) begin
                  // A request already issued must complete; drain it if the
                  // ack has not arrived, otherwise just drop the data
                  if (bus.imem_ack) begin
                     r_imem_req <= 1'b0;
                     r_state    <= S_UPDATE;
                  end else begin
                     r_state    <= S_DRAIN;
                  end
               end else if (bus.imem_ack) begin
                  r_imem_req   <= 1'b0;
                  r_inst_data  <= bus.imem_rdata;
                  r_inst_pc    <= r_addr;
                  r_inst_valid <= 1'b1;
                  r_state      <= S_HOLD;
               end
            end

            S_HOLD: begin
               // Redirect drops the held word even if decode was ready
               if (bus.redirect_valid || bus.inst_ready) begin
                  r_inst_valid <= 1'b0;
                  r_state      <= S_UPDATE;
               end
            end

            S_DRAIN: begin
               // Stale data is discarded; further redirects only re-pulse load
               if (bus.imem_ack) begin
                  r_imem_req <= 1'b0;
                  r_state    <= S_UPDATE;
               end
            end

            S_UPDATE: begin
               if (bus.redirect_valid) begin
                  r_state <= S_UPDATE;
               end else if (bus.fetch_en) begin
                  r_addr      <= bus.pc_current_address;
                  r_imem_req  <= 1'b1;
                  r_imem_addr <= bus.pc_current_address;
                  r_state     <= S_REQ;
               end else begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_imem_req   <= 1'b0;
               r_inst_valid <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.load           = w_load;
   assign bus.pc_target_addr = w_target;
   assign bus.imem_req       = r_imem_req;
   assign bus.imem_addr      = r_imem_addr;
   assign bus.inst_valid     = r_inst_valid;
   assign bus.inst_data      = r_inst_data;
   assign bus.inst_pc        = r_inst_pc;
   assign bus.misalign_err   = w_misalign_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer with a
//                behavioural PC register and an instruction scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 32;

`ifdef FETCH_ALIGN_CHECK_EN
   localparam logic [7:0] EXP_RD_TGT = 8'h20;
   localparam logic       EXP_MIS    = 1'b1;
`else
   localparam logic [7:0] EXP_RD_TGT = 8'h22;
   localparam logic       EXP_MIS    = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   fetch_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

   fetch_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .PC_STEP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Behavioural PC register: takes the target on every load pulse, not reset
   logic [7:0] pc = 8'h00;
   always @(posedge clk) begin
      if (bus.load) pc <= bus.pc_target_addr;
   end
   assign bus.pc_current_address = pc;

   // Scoreboard of instructions expected to be accepted by decode: {pc, data}
   logic [39:0] sb_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called in a cycle where decode accepts; pops and compares the held word
   task automatic sb_pop(input string tag);
      logic [39:0] e;
      tests++;
      assert (sb_q.size() > 0) else begin
         fails++;
         $error("FAIL %s: observed accept with empty scoreboard, expected queued entry", tag);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, "_pc"},   32'(bus.inst_pc),   32'(e[39:32]));
         chk({tag, "_data"}, bus.inst_data,      e[31:0]);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      bus.fetch_en       = 1'b0;
      bus.imem_ack       = 1'b0;
      bus.imem_rdata     = '0;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = '0;

      // ---------------- reset state ----------------
      tick(); tick(); settle();
      chk("rst_load",   32'(bus.load),           0);
      chk("rst_tgt",    32'(bus.pc_target_addr), 0);
      chk("rst_req",    32'(bus.imem_req),       0);
      chk("rst_iaddr",  32'(bus.imem_addr),      0);
      chk("rst_valid",  32'(bus.inst_valid),     0);
      chk("rst_data",   bus.inst_data,           0);
      chk("rst_ipc",    32'(bus.inst_pc),        0);
      chk("rst_mis",    32'(bus.misalign_err),   0);
      rst = 1'b1;

      // ---------------- zero-wait fetch, 3-cycle cadence ----------------
      bus.fetch_en = 1'b1;
      tick();                                   // REQ @0x00
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_1111; bus.inst_ready = 1'b1;
      sb_q.push_back({8'h00, 32'h1111_1111});
      settle();
      chk("t1_req",   32'(bus.imem_req),  1);
      chk("t1_addr",  32'(bus.imem_addr), 8'h00);
      chk("t1_noload",32'(bus.load),      0);
      tick();                                   // HOLD
      bus.imem_ack = 1'b0;
      settle();
      chk("t1_valid", 32'(bus.inst_valid),     1);
      chk("t1_load",  32'(bus.load),           1);
      chk("t1_tgt",   32'(bus.pc_target_addr), 8'h04);
      sb_pop("t1_sb");
      tick();                                   // UPDATE
      settle();
      chk("t1_upd_load",  32'(bus.load),       0);
      chk("t1_upd_valid", 32'(bus.inst_valid), 0);
      chk("t1_upd_req",   32'(bus.imem_req),   0);
      tick();                                   // REQ @0x04, 3 cycles after first
      settle();
      chk("t1_next_req",  32'(bus.imem_req),  1);
      chk("t1_next_addr", 32'(bus.imem_addr), 8'h04);

      // ---------------- ack delayed 3 cycles ----------------
      for (int i = 0; i < 3; i++) begin
         chk("t2_wait_req",   32'(bus.imem_req),   1);
         chk("t2_wait_addr",  32'(bus.imem_addr),  8'h04);
         chk("t2_wait_valid", 32'(bus.inst_valid), 0);
         chk("t2_wait_load",  32'(bus.load),       0);
         tick(); settle();
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2222_2222; bus.inst_ready = 1'b0;
      sb_q.push_back({8'h04, 32'h2222_2222});
      settle();
      chk("t2_ack_addr", 32'(bus.imem_addr), 8'h04);
      tick();                                   // HOLD
      bus.imem_ack = 1'b0;
      settle();
      chk("t2_valid_rise", 32'(bus.inst_valid), 1);

      // ---------------- decode stalls 4 cycles ----------------
      for (int i = 0; i < 4; i++) begin
         chk("t3_stall_valid", 32'(bus.inst_valid), 1);
         chk("t3_stall_data",  bus.inst_data,       32'h2222_2222);
         chk("t3_stall_load",  32'(bus.load),       0);
         tick(); settle();
      end
      bus.inst_ready = 1'b1;
      settle();
      chk("t3_load", 32'(bus.load),           1);
      chk("t3_tgt",  32'(bus.pc_target_addr), 8'h08);
      sb_pop("t3_sb");
      tick();                                   // UPDATE
      tick();                                   // REQ @0x08

      // ---------------- redirect while waiting for ack ----------------
      bus.redirect_valid = 1'b1; bus.redirect_addr = 8'h40;
      settle();
      chk("t4_req_addr", 32'(bus.imem_addr),      8'h08);
      chk("t4_load",     32'(bus.load),           1);
      chk("t4_tgt",      32'(bus.pc_target_addr), 8'h40);
      tick();                                   // DRAIN
      bus.redirect_valid = 1'b0; bus.redirect_addr = '0;
      settle();
      chk("t4_drain_req",  32'(bus.imem_req),  1);
      chk("t4_drain_addr", 32'(bus.imem_addr), 8'h08);
      chk("t4_drain_load", 32'(bus.load),      0);
      tick();
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;   // stale, never presented
      settle();
      chk("t4_drain_req2", 32'(bus.imem_req), 1);
      tick();                                   // UPDATE
      bus.imem_ack = 1'b0;
      settle();
      chk("t4_upd_valid", 32'(bus.inst_valid), 0);
      chk("t4_upd_req",   32'(bus.imem_req),   0);
      tick();                                   // REQ @0x40
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3333_3333;
      sb_q.push_back({8'h40, 32'h3333_3333});
      settle();
      chk("t4_new_addr",  32'(bus.imem_addr),  8'h40);
      chk("t4_new_valid", 32'(bus.inst_valid), 0);
      tick();                                   // HOLD
      bus.imem_ack = 1'b0;
      settle();
      chk("t4_tgt44", 32'(bus.pc_target_addr), 8'h44);
      sb_pop("t4_sb");
      tick();                                   // UPDATE, fetch_en low -> IDLE
      bus.fetch_en = 1'b0;
      tick();                                   // IDLE

      // ---------------- wraparound 0xFC -> 0x00 ----------------
      bus.redirect_valid = 1'b1; bus.redirect_addr = 8'hFC;
      settle();
      chk("t5_idle_req", 32'(bus.imem_req),       0);
      chk("t5_idle_tgt", 32'(bus.pc_target_addr), 8'hFC);
      tick();                                   // UPDATE
      bus.redirect_valid = 1'b0; bus.redirect_addr = '0; bus.fetch_en = 1'b1;
      tick();                                   // REQ @0xFC
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h4444_4444;
      sb_q.push_back({8'hFC, 32'h4444_4444});
      settle();
      chk("t5_addr", 32'(bus.imem_addr), 8'hFC);
      tick();                                   // HOLD
      bus.imem_ack = 1'b0;
      settle();
      chk("t5_load", 32'(bus.load),           1);
      chk("t5_wrap", 32'(bus.pc_target_addr), 8'h00);
      sb_pop("t5_sb");
      tick();                                   // UPDATE
      tick();                                   // REQ @0x00

      // ---------------- redirect in HOLD drops word; misaligned target ----------------
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h5555_5555;  // will be dropped
      settle();
      chk("t6_addr", 32'(bus.imem_addr), 8'h00);
      tick();                                   // HOLD
      bus.imem_ack = 1'b0;
      bus.redirect_valid = 1'b1; bus.redirect_addr = 8'h22;
      settle();
      chk("t6_valid", 32'(bus.inst_valid),     1);
      chk("t6_load",  32'(bus.load),           1);
      chk("t6_tgt",   32'(bus.pc_target_addr), 32'(EXP_RD_TGT));
      tick();                                   // UPDATE
      bus.redirect_valid = 1'b0; bus.redirect_addr = '0;
      settle();
      chk("t6_drop",   32'(bus.inst_valid),   0);
      chk("t6_mis",    32'(bus.misalign_err), 32'(EXP_MIS));
      tick();                                   // REQ @redirect target
      settle();
      chk("t6_req_addr", 32'(bus.imem_addr),    32'(EXP_RD_TGT));
      chk("t6_mis_hold", 32'(bus.misalign_err), 32'(EXP_MIS));

      // ---------------- async reset mid-REQ ----------------
      rst = 1'b0;
      settle();
      chk("t7_req",   32'(bus.imem_req),       0);
      chk("t7_iaddr", 32'(bus.imem_addr),      0);
      chk("t7_valid", 32'(bus.inst_valid),     0);
      chk("t7_data",  bus.inst_data,           0);
      chk("t7_ipc",   32'(bus.inst_pc),        0);
      chk("t7_mis",   32'(bus.misalign_err),   0);
      chk("t7_load",  32'(bus.load),           0);
      tick();
      rst = 1'b1;
      tick();                                   // IDLE -> REQ from current PC
      settle();
      chk("t7_restart_req",  32'(bus.imem_req),  1);
      chk("t7_restart_addr", 32'(bus.imem_addr), 32'(EXP_RD_TGT));

      chk("sb_empty", 32'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: observed no completion, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
